uart_serdes: RTL and testbench

- 8N1 UART serializer/deserializer downstream of the memory/MMIO block.
- Consumes the byte-write strobe and data produced by the MMIO write path at UART_WRITE_ADDR, and drives tx_line.
- Deserializes rx_line into a one-byte holding register. The status bits rx_ready/tx_ready and the byte rx_data_output are read back by the MMIO read path; rx_ready also drives meip.

---
 rtl/uart_serdes_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_serdes.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_serdes.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_serdes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_serdes_pkg
//  Purpose  : Shared state encodings and frame constants for the 8N1 UART.
//  Revision : 1.0  initial release
// ============================================================================
package uart_serdes_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : DEPTH-entry synchronous byte FIFO feeding the UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_serdes_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] pop_data,
    output logic                      full,
    output logic                      empty
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]           r_wr_ptr;
    logic [c_aw-1:0]           r_rd_ptr;
    logic [c_aw:0]             r_count;
    logic                      w_push_ok;
    logic                      w_pop_ok;

    // Writes while full are dropped; the pointers wrap at the power-of-two depth.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_serdes.sv
`default_nettype none
// ============================================================================
//  Module   : uart_serdes
//  Purpose  : 8N1 UART with TX FIFO, RX holding register and status flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_serdes
    import uart_serdes_pkg::*;
#(
    parameter int DEPTH        = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_fifo_write_en,
    input  logic [7:0]  uart_fifo_data,
    input  logic        cpu_read,
    input  logic        rx_line,
    output logic        tx_line,
    output logic        tx_ready,
    output logic        rx_ready,
    output logic [31:0] rx_data_output,
    output logic        rx_overrun,
    output logic        rx_frame_err
);

    localparam int              c_bw        = $clog2(CLKS_PER_BIT);
    localparam logic [c_bw-1:0] c_bit_last  = c_bw'(CLKS_PER_BIT - 1);
    localparam logic [c_bw-1:0] c_half_last = c_bw'(CLKS_PER_BIT / 2 - 1);
    localparam int              c_iw        = $clog2(UART_DATA_BITS);
    localparam logic [c_iw-1:0] c_idx_last  = c_iw'(UART_DATA_BITS - 1);

    // ------------------------------------------------------------------ TX
    logic [UART_DATA_BITS-1:0] w_fifo_data;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_tx_pop;

    tx_state_t                 r_tx_state;
    logic [c_bw-1:0]           r_tx_baud;
    logic [c_iw-1:0]           r_tx_bit;
    logic [UART_DATA_BITS-1:0] r_tx_shift;

    uart_tx_fifo #(
        .DEPTH     (DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (uart_fifo_write_en),
        .push_data (uart_fifo_data),
        .pop       (w_tx_pop),
        .pop_data  (w_fifo_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign tx_ready = !w_fifo_full;

    // Pop either from idle or at the end of a stop bit so frames run back to back.
    assign w_tx_pop = !w_fifo_empty &&
                      ((r_tx_state == TX_IDLE) ||
                       ((r_tx_state == TX_STOP) && (r_tx_baud == c_bit_last)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            tx_line    <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_shift <= w_fifo_data;
                        r_tx_baud  <= '0;
                        tx_line    <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_baud == c_bit_last) begin
                        r_tx_baud  <= '0;
                        r_tx_bit   <= '0;
                        tx_line    <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_baud == c_bit_last) begin
                        r_tx_baud <= '0;
                        if (r_tx_bit == c_idx_last) begin
                            tx_line    <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                            tx_line  <= r_tx_shift[r_tx_bit + 1'b1];
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_baud == c_bit_last) begin
                        r_tx_baud <= '0;
                        if (w_tx_pop) begin
                            r_tx_shift <= w_fifo_data;
                            tx_line    <= 1'b0;
                            r_tx_state <= TX_START;
                        end else begin
                            r_tx_state <= TX_IDLE;
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    logic                      r_rx_meta;
    logic                      r_rx_s;
    rx_state_t                 r_rx_state;
    logic [c_bw-1:0]           r_rx_baud;
    logic [c_iw-1:0]           r_rx_bit;
    logic [UART_DATA_BITS-1:0] r_rx_shift;
    logic [UART_DATA_BITS-1:0] r_rx_hold;
    logic                      w_rx_stop_sample;
    logic                      w_rx_deliver;
    logic                      w_rx_bad_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_line;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_rx_stop_sample = (r_rx_state == RX_STOP) && (r_rx_baud == c_bit_last);
    assign w_rx_deliver     = w_rx_stop_sample && r_rx_s;
    assign w_rx_bad_stop    = w_rx_stop_sample && !r_rx_s;

    // Counting from the start-bit edge puts every later sample mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_s) begin
                        r_rx_baud  <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_baud == c_half_last) begin
                        r_rx_baud  <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_baud == c_bit_last) begin
                        r_rx_baud  <= '0;
                        r_rx_shift <= {r_rx_s, r_rx_shift[UART_DATA_BITS-1:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == c_idx_last) r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_baud == c_bit_last) begin
                        r_rx_baud  <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_baud <= r_rx_baud + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // A read in the delivery cycle frees the slot, so the new byte is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_hold    <= '0;
            rx_ready     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= w_rx_bad_stop;
            if (w_rx_deliver) begin
                if (!rx_ready || cpu_read) begin
                    r_rx_hold <= r_rx_shift;
                    rx_ready  <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (cpu_read) begin
                rx_ready <= 1'b0;
            end
        end
    end

    assign rx_data_output = {{(32 - UART_DATA_BITS){1'b0}}, r_rx_hold};

endmodule
`default_nettype wire

// File: tb/tb_uart_serdes.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_serdes
//  Purpose  : Directed self-checking bench for uart_serdes (DEPTH=4, 4 clk/bit).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_serdes;

    localparam int DEPTH = 4;
    localparam int CPB   = 4;

    logic        clk                = 1'b0;
    logic        rst                = 1'b1;
    logic        uart_fifo_write_en = 1'b0;
    logic [7:0]  uart_fifo_data     = 8'h00;
    logic        cpu_read           = 1'b0;
    logic        rx_line            = 1'b1;
    logic        tx_line;
    logic        tx_ready;
    logic        rx_ready;
    logic [31:0] rx_data_output;
    logic        rx_overrun;
    logic        rx_frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_serdes #(
        .DEPTH              (DEPTH),
        .CLKS_PER_BIT       (CPB)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .uart_fifo_write_en (uart_fifo_write_en),
        .uart_fifo_data     (uart_fifo_data),
        .cpu_read           (cpu_read),
        .rx_line            (rx_line),
        .tx_line            (tx_line),
        .tx_ready           (tx_ready),
        .rx_ready           (rx_ready),
        .rx_data_output     (rx_data_output),
        .rx_overrun         (rx_overrun),
        .rx_frame_err       (rx_frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Walk a TX frame cycle by cycle; 'first' skips cycles already elapsed.
    task automatic expect_frame(input logic [7:0] b, input int first, input string tag);
        for (int i = first; i < 10 * CPB; i++) begin
            int   slot;
            logic e;
            slot = i / CPB;
            if (slot == 0)      e = 1'b0;
            else if (slot == 9) e = 1'b1;
            else                e = b[slot-1];
            check(tag, 32'(tx_line), 32'(e));
            tick(1);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx_line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            tick(CPB);
        end
        rx_line = stop_bit;
        tick(CPB);
        rx_line = 1'b1;
    endtask

    task automatic burst(input int n);
        for (int i = 1; i <= n; i++) begin
            uart_fifo_write_en = 1'b1;
            uart_fifo_data     = 8'(i);
            tick(1);
        end
        uart_fifo_write_en = 1'b0;
        check("burst_tx_ready_full", 32'(tx_ready), 32'd0);
        expect_frame(8'h01, n - 2, "burst_frame1");
        check("burst_tx_ready_after_pop", 32'(tx_ready), 32'd1);
        for (int i = 2; i <= 5; i++) expect_frame(8'(i), 0, "burst_frame_n");
    endtask

    task automatic expect_tx_quiet(input int cycles, input string tag);
        logic low_seen;
        low_seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_line !== 1'b1) low_seen = 1'b1;
            tick(1);
        end
        check(tag, 32'(low_seen), 32'd0);
    endtask

    initial begin
        logic seen_err;
        logic seen_ready;

        tick(3);
        rst = 1'b0;
        tick(100);
        check("rst_tx_line",   32'(tx_line),      32'd1);
        check("rst_tx_ready",  32'(tx_ready),     32'd1);
        check("rst_rx_ready",  32'(rx_ready),     32'd0);
        check("rst_rx_data",   rx_data_output,    32'd0);
        check("rst_overrun",   32'(rx_overrun),   32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);

        // Single frame 0xA5
        uart_fifo_write_en = 1'b1;
        uart_fifo_data     = 8'hA5;
        tick(1);
        uart_fifo_write_en = 1'b0;
        check("a5_still_idle", 32'(tx_line), 32'd1);
        tick(1);
        expect_frame(8'hA5, 0, "a5_frame");
        expect_tx_quiet(10, "a5_idle_after");

        burst(5);
        expect_tx_quiet(50, "burst5_idle_after");
        burst(6);
        expect_tx_quiet(50, "burst6_sixth_dropped");

        // RX basic delivery and cpu_read
        send_rx(8'h3C, 1'b1);
        tick(1);
        check("rx3c_ready", 32'(rx_ready),  32'd1);
        check("rx3c_data",  rx_data_output, 32'h0000_003C);
        cpu_read = 1'b1;
        tick(1);
        cpu_read = 1'b0;
        check("rx3c_read_clears", 32'(rx_ready),   32'd0);
        check("rx3c_data_held",   rx_data_output,  32'h0000_003C);
        check("rx3c_no_overrun",  32'(rx_overrun), 32'd0);

        // Overrun
        tick(10);
        send_rx(8'h11, 1'b1);
        tick(1);
        check("ovr_first_data", rx_data_output, 32'h11);
        tick(10);
        send_rx(8'h22, 1'b1);
        tick(1);
        check("ovr_data_kept", rx_data_output,  32'h11);
        check("ovr_flag",      32'(rx_overrun), 32'd1);
        check("ovr_ready",     32'(rx_ready),   32'd1);

        // Reset clears sticky overrun; then read coincident with delivery
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst2_overrun", 32'(rx_overrun), 32'd0);
        check("rst2_ready",   32'(rx_ready),   32'd0);
        check("rst2_data",    rx_data_output,  32'd0);
        tick(5);
        send_rx(8'h11, 1'b1);
        tick(1);
        check("same_first_data", rx_data_output, 32'h11);
        tick(10);
        send_rx(8'h22, 1'b1);
        cpu_read = 1'b1;
        tick(1);
        cpu_read = 1'b0;
        check("same_data_replaced", rx_data_output,  32'h22);
        check("same_ready",         32'(rx_ready),   32'd1);
        check("same_no_overrun",    32'(rx_overrun), 32'd0);
        cpu_read = 1'b1;
        tick(1);
        cpu_read = 1'b0;
        check("same_read_clears", 32'(rx_ready), 32'd0);

        // Bad stop bit
        tick(10);
        send_rx(8'h55, 1'b0);
        tick(1);
        check("ferr_pulse",    32'(rx_frame_err), 32'd1);
        check("ferr_no_ready", 32'(rx_ready),     32'd0);
        tick(1);
        check("ferr_one_cycle", 32'(rx_frame_err), 32'd0);
        tick(20);

        // One-cycle glitch must be rejected; receiver still works after
        seen_err   = 1'b0;
        seen_ready = 1'b0;
        rx_line    = 1'b0;
        tick(1);
        rx_line = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (rx_frame_err) seen_err = 1'b1;
            if (rx_ready)     seen_ready = 1'b1;
            tick(1);
        end
        check("glitch_no_err",   32'(seen_err),   32'd0);
        check("glitch_no_ready", 32'(seen_ready), 32'd0);
        send_rx(8'h96, 1'b1);
        tick(1);
        check("post_glitch_data", rx_data_output, 32'h96);

        // Reset mid-TX frame aborts it and empties the FIFO
        uart_fifo_write_en = 1'b1;
        uart_fifo_data     = 8'h00;
        tick(1);
        uart_fifo_data = 8'hFF;
        tick(1);
        uart_fifo_write_en = 1'b0;
        tick(10);
        check("midtx_line_low", 32'(tx_line), 32'd0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midtx_rst_line",  32'(tx_line),  32'd1);
        check("midtx_rst_ready", 32'(tx_ready), 32'd1);
        expect_tx_quiet(60, "midtx_fifo_empty");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
